// File: rtl/motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// motor_pwm_driver
//
// Dual-channel H-bridge PWM output stage. It sits after the overcurrent
// protection block and turns that block's per-channel enables, together with
// the duty and direction commands, into the four bridge gate inputs.
//
// A single free-running counter is shared by both channels. Each channel
// latches its duty command when the counter wraps, so a period is never
// glitched mid-way. Each channel runs its own OFF / DEAD / RUN state machine.
// Every entry into RUN goes through a dead-time interval of DEAD_CYC cycles
// with both bridge inputs low. Dropping the enable forces the channel off on
// the next edge.
//
// Parameters:
//   CNT_W     PWM counter width; the PWM period is 2**CNT_W clk cycles.
//   DEAD_CYC  dead-time length in clk cycles; must be at least 1.
//
// Ports:
//   clk            system clock; all state changes on its rising edge
//   rst_n          synchronous active-low reset
//   ena, enb       channel enables from the overcurrent block (1 = may drive)
//   duty_a/_b      duty command, in on-cycles per period
//   dir_a/_b       direction command (1 = forward, 0 = reverse)
//   a_in1, a_in2   channel A bridge inputs (registered)
//   b_in1, b_in2   channel B bridge inputs (registered)
//   busy_a/_b      channel is in dead time (registered)
// -----------------------------------------------------------------------------
module motor_pwm_driver #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned DEAD_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             enb,
    input  logic [CNT_W-1:0] duty_a,
    input  logic [CNT_W-1:0] duty_b,
    input  logic             dir_a,
    input  logic             dir_b,
    output logic             a_in1,
    output logic             a_in2,
    output logic             b_in1,
    output logic             b_in2,
    output logic             busy_a,
    output logic             busy_b
);

    // Wide enough to hold DEAD_CYC itself.
    localparam int unsigned TMR_W = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DEAD_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam int unsigned NCH = 2;

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StDead = 2'd1,
        StRun  = 2'd2
    } state_e;

    // Channel index 0 is A, 1 is B.
    logic [NCH-1:0] en_in;
    logic [NCH-1:0] dir_in;
    logic [CNT_W-1:0] duty_in [NCH];

    assign en_in      = {enb, ena};
    assign dir_in     = {dir_b, dir_a};
    assign duty_in[0] = duty_a;
    assign duty_in[1] = duty_b;

    // State
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_lat_q [NCH];
    logic [CNT_W-1:0] duty_lat_d [NCH];
    logic [NCH-1:0]   active_dir_q, active_dir_d;
    logic [NCH-1:0]   dir_prev_q, dir_prev_d;
    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [TMR_W-1:0] timer_q [NCH];
    logic [TMR_W-1:0] timer_d [NCH];
    logic [NCH-1:0]   in1_q, in1_d;
    logic [NCH-1:0]   in2_q, in2_d;
    logic [NCH-1:0]   busy_q, busy_d;

    logic             cnt_wrap;
    logic [NCH-1:0]   pwm;

    // -------------------------------------------------------------------------
    // Shared counter and duty latches
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_wrap = (cnt_q == {CNT_W{1'b1}});
        cnt_d    = cnt_q + 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            // Only take a new duty on the wrap edge so the whole period uses one value.
            duty_lat_d[ch] = cnt_wrap ? duty_in[ch] : duty_lat_q[ch];
            // A latched duty of all-ones still leaves the last count low.
            pwm[ch]        = (cnt_q < duty_lat_q[ch]);
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel state machine and output next-state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            state_d[ch]      = state_q[ch];
            timer_d[ch]      = timer_q[ch];
            active_dir_d[ch] = active_dir_q[ch];
            dir_prev_d[ch]   = dir_in[ch];

            if (!en_in[ch]) begin
                // Losing the enable beats any other event, including a reversal.
                state_d[ch] = StOff;
                timer_d[ch] = '0;
            end else begin
                case (state_q[ch])
                    StOff: begin
                        state_d[ch] = StDead;
                        timer_d[ch] = TMR_LOAD;
                    end
                    StDead: begin
                        if (dir_in[ch] != dir_prev_q[ch]) begin
                            // Direction moved again: restart the full dead time.
                            timer_d[ch] = TMR_LOAD;
                        end else if (timer_q[ch] <= TMR_ONE) begin
                            state_d[ch]      = StRun;
                            timer_d[ch]      = '0;
                            active_dir_d[ch] = dir_in[ch];
                        end else begin
                            timer_d[ch] = timer_q[ch] - 1'b1;
                        end
                    end
                    StRun: begin
                        if (dir_in[ch] != active_dir_q[ch]) begin
                            state_d[ch] = StDead;
                            timer_d[ch] = TMR_LOAD;
                        end
                    end
                    default: begin
                        state_d[ch] = StOff;
                        timer_d[ch] = '0;
                    end
                endcase
            end

            // Outputs follow the state being entered, so a forced-off or a
            // reversal shows as 00 on the very edge that takes effect. Only one
            // of in1/in2 can ever be set since active_dir selects exactly one.
            in1_d[ch]  = (state_d[ch] == StRun) &&  active_dir_d[ch] && pwm[ch];
            in2_d[ch]  = (state_d[ch] == StRun) && !active_dir_d[ch] && pwm[ch];
            busy_d[ch] = (state_d[ch] == StDead);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            active_dir_q <= '1;
            dir_prev_q   <= '1;
            in1_q        <= '0;
            in2_q        <= '0;
            busy_q       <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                duty_lat_q[ch] <= '0;
                state_q[ch]    <= StOff;
                timer_q[ch]    <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            active_dir_q <= active_dir_d;
            dir_prev_q   <= dir_prev_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            busy_q       <= busy_d;
            for (int ch = 0; ch < NCH; ch++) begin
                duty_lat_q[ch] <= duty_lat_d[ch];
                state_q[ch]    <= state_d[ch];
                timer_q[ch]    <= timer_d[ch];
            end
        end
    end

    assign a_in1  = in1_q[0];
    assign a_in2  = in2_q[0];
    assign b_in1  = in1_q[1];
    assign b_in2  = in2_q[1];
    assign busy_a = busy_q[0];
    assign busy_b = busy_q[1];

endmodule

// File: tb/tb_motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm_driver
//
// Directed bench for motor_pwm_driver with CNT_W=4, DEAD_CYC=3. A cycle model
// predicts the six outputs for every edge; predictions are queued when the
// inputs are applied and compared once the edge has produced them. Directed
// checks with hand-derived counts cover each scenario on top of that.
// -----------------------------------------------------------------------------
module tb_motor_pwm_driver;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DEAD_CYC = 3;
    localparam int unsigned PERIOD   = 16;

    localparam int MOff  = 0;
    localparam int MDead = 1;
    localparam int MRun  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena, enb;
    logic [CNT_W-1:0] duty_a, duty_b;
    logic             dir_a, dir_b;
    logic             a_in1, a_in2, b_in1, b_in2;
    logic             busy_a, busy_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Per-window high counts, accumulated by tick().
    int n_a1, n_a2, n_b1, n_b2, n_ba, n_bb;

    // Reference model state
    int unsigned m_cnt;
    int unsigned m_lat   [2];
    bit          m_adir  [2];
    int          m_mode  [2];
    int          m_left  [2];
    bit          m_dprev [2];

    logic [5:0] exp_q[$];

    motor_pwm_driver #(
        .CNT_W   (CNT_W),
        .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .enb   (enb),
        .duty_a(duty_a),
        .duty_b(duty_b),
        .dir_a (dir_a),
        .dir_b (dir_b),
        .a_in1 (a_in1),
        .a_in2 (a_in2),
        .b_in1 (b_in1),
        .b_in2 (b_in2),
        .busy_a(busy_a),
        .busy_b(busy_b)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            m_lat[c]   = 0;
            m_adir[c]  = 1'b1;
            m_mode[c]  = MOff;
            m_left[c]  = 0;
            m_dprev[c] = 1'b1;
        end
    endtask

    // Predict what the coming edge produces from the inputs now applied.
    task automatic model_step();
        bit          en [2];
        bit          dr [2];
        int unsigned du [2];
        bit          on [2];
        bit          o1 [2];
        bit          o2 [2];
        bit          bz [2];
        en[0] = ena;  en[1] = enb;
        dr[0] = dir_a; dr[1] = dir_b;
        du[0] = duty_a; du[1] = duty_b;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(6'b000000);
            return;
        end
        for (int c = 0; c < 2; c++) begin
            on[c] = (m_cnt < m_lat[c]);
            if (!en[c]) begin
                m_mode[c] = MOff;
                m_left[c] = 0;
            end else if (m_mode[c] == MOff) begin
                m_mode[c] = MDead;
                m_left[c] = DEAD_CYC;
            end else if (m_mode[c] == MDead) begin
                if (dr[c] != m_dprev[c]) begin
                    m_left[c] = DEAD_CYC;
                end else begin
                    m_left[c] = m_left[c] - 1;
                    if (m_left[c] == 0) begin
                        m_mode[c] = MRun;
                        m_adir[c] = dr[c];
                    end
                end
            end else if (dr[c] != m_adir[c]) begin
                m_mode[c] = MDead;
                m_left[c] = DEAD_CYC;
            end
            m_dprev[c] = dr[c];
            o1[c] = (m_mode[c] == MRun) && m_adir[c] && on[c];
            o2[c] = (m_mode[c] == MRun) && !m_adir[c] && on[c];
            bz[c] = (m_mode[c] == MDead);
        end
        if (m_cnt == PERIOD - 1) begin
            m_lat[0] = du[0];
            m_lat[1] = du[1];
        end
        m_cnt = (m_cnt + 1) % PERIOD;
        exp_q.push_back({o1[0], o2[0], o1[1], o2[1], bz[0], bz[1]});
    endtask

    task automatic clear_counts();
        n_a1 = 0; n_a2 = 0; n_b1 = 0; n_b2 = 0; n_ba = 0; n_bb = 0;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: queue the prediction, take the edge, compare away from it.
    task automatic tick();
        logic [5:0] got;
        logic [5:0] exp_v;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        got = {a_in1, a_in2, b_in1, b_in2, busy_a, busy_b};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty cyc=%0d observed=%b expected=<none>", cyc, got);
        end else begin
            exp_v = exp_q.pop_front();
            assert (got === exp_v) else begin
                failures++;
                $error("FAIL sb cyc=%0d observed=%b expected=%b", cyc, got, exp_v);
            end
        end
        checks++;
        assert ({a_in1 & a_in2, b_in1 & b_in2} === 2'b00) else begin
            failures++;
            $error("FAIL overlap cyc=%0d observed=%b%b%b%b expected=no pair high",
                   cyc, a_in1, a_in2, b_in1, b_in2);
        end
        if (a_in1)  n_a1++;
        if (a_in2)  n_a2++;
        if (b_in1)  n_b1++;
        if (b_in2)  n_b2++;
        if (busy_a) n_ba++;
        if (busy_b) n_bb++;
    endtask

    // Advance until the model counter has just wrapped to 0 (at least one edge).
    task automatic wait_wrap();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (m_cnt != 0 && n < 40);
    endtask

    initial begin
        int nb;
        rst_n  = 1'b0;
        ena    = 1'b0;
        enb    = 1'b0;
        duty_a = '0;
        duty_b = '0;
        dir_a  = 1'b1;
        dir_b  = 1'b1;
        model_reset();
        clear_counts();

        // Reset held two cycles
        tick();
        tick();
        check("reset_outs", int'({a_in1, a_in2, b_in1, b_in2, busy_a, busy_b}), 0);
        check("reset_cnt", int'(dut.cnt_q), 0);

        // Enable both channels: three cycles of dead time first
        rst_n  = 1'b1;
        ena    = 1'b1;
        enb    = 1'b1;
        duty_a = 4'd4;
        duty_b = 4'd8;
        clear_counts();
        repeat (6) tick();
        check("start_busy_a", n_ba, 3);
        check("start_busy_b", n_bb, 3);
        check("start_a_in2", n_a2, 0);

        // First full period after the wrap: 4 high on A, 8 on B, 1-cycle lag
        wait_wrap();
        clear_counts();
        tick();
        check("lag_cnt0_high", int'(a_in1), 1);
        repeat (3) tick();
        tick();
        check("lag_cnt4_low", int'(a_in1), 0);
        repeat (11) tick();
        check("period_a_duty4", n_a1, 4);
        check("period_b_duty8", n_b1, 8);
        check("period_a_in2", n_a2, 0);

        // Duty change at cnt=7 only takes effect next period
        clear_counts();
        repeat (7) tick();
        duty_a = 4'd10;
        repeat (9) tick();
        check("dutychg_cur", n_a1, 4);
        clear_counts();
        repeat (16) tick();
        check("dutychg_next", n_a1, 10);

        // Reversal in RUN
        dir_a = 1'b0;
        clear_counts();
        repeat (3) tick();
        check("rev_busy", n_ba, 3);
        check("rev_outs_off", n_a1 + n_a2, 0);
        tick();
        check("rev_busy_end", int'(busy_a), 0);
        wait_wrap();
        clear_counts();
        repeat (16) tick();
        check("rev_a_in2", n_a2, 10);
        check("rev_a_in1", n_a1, 0);

        // Two more changes inside dead time restart the timer
        dir_a = 1'b1;
        tick();
        dir_a = 1'b0;
        tick();
        dir_a = 1'b1;
        tick();
        clear_counts();
        repeat (3) tick();
        check("toggle_busy", n_ba, 2);
        check("toggle_run", int'(busy_a), 0);
        wait_wrap();
        clear_counts();
        repeat (16) tick();
        check("toggle_a_in1", n_a1, 10);
        check("toggle_a_in2", n_a2, 0);

        // One-cycle enable drop at duty 15
        duty_a = 4'd15;
        wait_wrap();
        clear_counts();
        repeat (3) tick();
        check("drop_pre", int'(a_in1), 1);
        ena = 1'b0;
        tick();
        check("drop_off", int'({a_in1, a_in2, busy_a}), 0);
        ena = 1'b1;
        nb  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy_a) nb++;
        end
        check("drop_redead", nb, 3);
        tick();
        check("drop_run_busy", int'(busy_a), 0);
        check("drop_run_in1", int'(a_in1), 1);
        repeat (8) tick();
        check("drop_b_in1", n_b1, 8);
        check("drop_b_in2", n_b2, 0);

        // Reset with A in dead time and B running
        dir_a = 1'b0;
        tick();
        check("midrst_a_dead", int'(busy_a), 1);
        rst_n = 1'b0;
        tick();
        check("midrst_outs", int'({a_in1, a_in2, b_in1, b_in2, busy_a, busy_b}), 0);
        check("midrst_cnt", int'(dut.cnt_q), 0);
        rst_n = 1'b1;

        // Zero duty on both channels: nothing ever drives
        duty_a = '0;
        duty_b = '0;
        clear_counts();
        repeat (40) tick();
        check("duty0_outs", n_a1 + n_a2 + n_b1 + n_b2, 0);
        check("duty0_busy_a", n_ba, 3);
        check("duty0_busy_b", n_bb, 3);

        // Enable falling with a direction change, then rising with one
        ena   = 1'b0;
        dir_a = 1'b1;
        tick();
        check("simul_fall_off", int'(busy_a), 0);
        ena   = 1'b1;
        dir_a = 1'b0;
        duty_a = 4'd12;
        tick();
        check("simul_rise_dead", int'(busy_a), 1);
        repeat (3) tick();
        check("simul_rise_run", int'(busy_a), 0);
        wait_wrap();
        clear_counts();
        repeat (16) tick();
        check("simul_dir_taken", n_a2, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
